// File: rtl/rd_control.sv
// rtl/rd_control.sv - UART configuration read-back controller
//
// Snapshots the configuration register bank on a start request and sends it
// byte 0 first through the UART transmitter, pacing every byte on the
// transmitter's ready flag (drop = byte taken, rise = byte finished).
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active low
//   start_rd   read-back request (level); sampled only while idle or holding
//   conf_data  configuration bank, byte 0 = conf_data[7:0]
//   tx_rdy     UART TX idle flag (1 = can accept a byte)
//   tx_data    byte presented to the UART, registered
//   tx_start   one-cycle load strobe to the UART, registered
//   done_rd    one-cycle pulse once the final byte has left the UART
//   busy       high from the accepted request until done_rd
//   rd_leds    index of the byte currently in flight

module rd_control #(
    parameter int NUM_BYTES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_rd,
    input  logic [8*NUM_BYTES-1:0] conf_data,
    input  logic                   tx_rdy,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    output logic                   done_rd,
    output logic                   busy,
    output logic [2:0]             rd_leds
);

    localparam int         SHREG_W  = 8 * NUM_BYTES;
    localparam logic [2:0] LAST_IDX = 3'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_IDLE,
        DONE,
        HOLD
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [SHREG_W-1:0]   shreg;
    logic [SHREG_W-1:0]   shreg_next;
    logic [2:0]           cnt;
    logic [2:0]           cnt_next;
    logic [7:0]           tx_data_next;
    logic                 tx_start_next;
    logic                 done_next;
    logic                 busy_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            done_rd  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            cnt      <= cnt_next;
            tx_data  <= tx_data_next;
            tx_start <= tx_start_next;
            done_rd  <= done_next;
            busy     <= busy_next;
        end
    end

    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        cnt_next      = cnt;
        tx_data_next  = tx_data;
        tx_start_next = 1'b0;
        done_next     = 1'b0;
        busy_next     = busy;

        case (state)
            IDLE: begin
                if (start_rd) begin
                    // The whole bank is captured here so later register
                    // writes cannot tear the transfer.
                    shreg_next = conf_data;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (tx_rdy) begin
                    tx_data_next  = shreg[7:0];
                    tx_start_next = 1'b1;
                    state_next    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // Only the falling ready proves the UART latched the byte;
                // a lingering or glitching high is not progress.
                if (!tx_rdy) begin
                    state_next = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (tx_rdy) begin
                    if (cnt == LAST_IDX) begin
                        // Outputs are registered, so the pulse and the busy
                        // drop are visible while the FSM sits in DONE.
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        state_next = DONE;
                    end else begin
                        cnt_next   = cnt + 3'd1;
                        shreg_next = shreg >> 8;
                        state_next = SEND;
                    end
                end
            end
            DONE: begin
                state_next = HOLD;
            end
            HOLD: begin
                // A level request must be released before it can rearm.
                if (!start_rd) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rd_leds = cnt;

endmodule

// File: tb/tb_rd_control.sv
// tb/tb_rd_control.sv - self-checking bench for rd_control

module tb_rd_control;

    logic        clk;
    logic        rst;
    logic        start8, start1;
    logic        rdy8, rdy1;
    logic [63:0] conf8;
    logic [7:0]  conf1;

    logic [7:0]  txd8, txd1;
    logic        txs8, txs1;
    logic        done8, done1;
    logic        busy8, busy1;
    logic [2:0]  leds8, leds1;

    rd_control #(.NUM_BYTES(8)) dut8 (
        .clk(clk), .rst(rst), .start_rd(start8), .conf_data(conf8),
        .tx_rdy(rdy8), .tx_data(txd8), .tx_start(txs8), .done_rd(done8),
        .busy(busy8), .rd_leds(leds8)
    );

    rd_control #(.NUM_BYTES(1)) dut1 (
        .clk(clk), .rst(rst), .start_rd(start1), .conf_data(conf1),
        .tx_rdy(rdy1), .tx_data(txd1), .tx_start(txs1), .done_rd(done1),
        .busy(busy1), .rd_leds(leds1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transfer is a list of snapshot bytes plus a cursor;
    // each byte is offered when the UART is ready, then must be seen taken
    // (ready low) and finished (ready high) before the cursor moves on.
    logic       m_active   [2];
    logic       m_offered  [2];
    logic       m_taken    [2];
    logic       m_rearm    [2];
    logic [7:0] m_bytes    [2][8];
    int         m_idx      [2];
    logic [7:0] e_txd      [2];
    logic       e_txs      [2];
    logic       e_done     [2];
    logic       e_busy     [2];
    logic [2:0] e_leds     [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_active[d] = 0; m_offered[d] = 0; m_taken[d] = 0; m_rearm[d] = 0;
            m_idx[d] = 0; e_txd[d] = 0; e_txs[d] = 0; e_done[d] = 0;
            e_busy[d] = 0; e_leds[d] = 0;
        end
    end

    task automatic model_step(input int d, input int n, input logic r, input logic s,
                              input logic rdy, input logic [63:0] cd);
        logic was_done;
        was_done = e_done[d];
        e_txs[d]  = 1'b0;
        e_done[d] = 1'b0;
        if (!r) begin
            m_active[d] = 0; m_offered[d] = 0; m_taken[d] = 0; m_rearm[d] = 0;
            m_idx[d] = 0; e_txd[d] = 0; e_busy[d] = 0; e_leds[d] = 0;
        end else if (!m_active[d]) begin
            if (was_done) begin
                m_rearm[d] = 1'b1;
            end else if (m_rearm[d]) begin
                if (!s) m_rearm[d] = 1'b0;
            end else if (s) begin
                for (int i = 0; i < 8; i++) m_bytes[d][i] = cd[8*i +: 8];
                m_active[d]  = 1'b1;
                m_offered[d] = 1'b0;
                m_idx[d]     = 0;
                e_busy[d]    = 1'b1;
                e_leds[d]    = 3'd0;
            end
        end else if (!m_offered[d]) begin
            if (rdy) begin
                e_txd[d]     = m_bytes[d][m_idx[d]];
                e_txs[d]     = 1'b1;
                m_offered[d] = 1'b1;
                m_taken[d]   = 1'b0;
            end
        end else if (!m_taken[d]) begin
            if (!rdy) m_taken[d] = 1'b1;
        end else if (rdy) begin
            if (m_idx[d] == n - 1) begin
                m_active[d] = 1'b0;
                e_busy[d]   = 1'b0;
                e_done[d]   = 1'b1;
            end else begin
                m_idx[d]     = m_idx[d] + 1;
                e_leds[d]    = 3'(m_idx[d]);
                m_offered[d] = 1'b0;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 8, rst, start8, rdy8, conf8);
        model_step(1, 1, rst, start1, rdy1, {56'd0, conf1});
    end

    always @(negedge clk) begin
        cmp("n8 tx_start", {63'd0, txs8}, {63'd0, e_txs[0]});
        cmp("n8 tx_data",  {56'd0, txd8}, {56'd0, e_txd[0]});
        cmp("n8 done_rd",  {63'd0, done8}, {63'd0, e_done[0]});
        cmp("n8 busy",     {63'd0, busy8}, {63'd0, e_busy[0]});
        cmp("n8 rd_leds",  {61'd0, leds8}, {61'd0, e_leds[0]});
        cmp("n1 tx_start", {63'd0, txs1}, {63'd0, e_txs[1]});
        cmp("n1 tx_data",  {56'd0, txd1}, {56'd0, e_txd[1]});
        cmp("n1 done_rd",  {63'd0, done1}, {63'd0, e_done[1]});
        cmp("n1 busy",     {63'd0, busy1}, {63'd0, e_busy[1]});
        cmp("n1 rd_leds",  {61'd0, leds1}, {61'd0, e_leds[1]});
    end

    // Directed-test monitor and reactive UART: ready drops the cycle after a
    // strobe and returns after ten low cycles.
    logic       react8, react1;
    int         low8, low1;
    logic [7:0] log8[$];
    logic [2:0] led_log8[$];
    logic [7:0] log1[$];
    int         dcnt8, dcnt1;

    task automatic tick();
        @(negedge clk);
        if (txs8) begin log8.push_back(txd8); led_log8.push_back(leds8); end
        if (done8) dcnt8++;
        if (txs1) log1.push_back(txd1);
        if (done1) dcnt1++;
        if (react8) begin
            if (txs8) begin rdy8 = 1'b0; low8 = 10; end
            else if (low8 > 0) begin low8--; if (low8 == 0) rdy8 = 1'b1; end
        end
        if (react1) begin
            if (txs1) begin rdy1 = 1'b0; low1 = 10; end
            else if (low1 > 0) begin low1--; if (low1 == 0) rdy1 = 1'b1; end
        end
    endtask

    task automatic clear_logs();
        log8.delete(); led_log8.delete(); log1.delete();
        dcnt8 = 0; dcnt1 = 0;
    endtask

    task automatic wait_done8(input string name, input int lim);
        int k;
        k = 0;
        while (dcnt8 == 0 && k < lim) begin tick(); k++; end
        cmp(name, {63'd0, dcnt8 != 0}, 64'd1);
    endtask

    initial begin
        rst = 0; start8 = 1; start1 = 0; rdy8 = 1; rdy1 = 0;
        conf8 = 64'h0807060504030201; conf1 = 8'h00;
        react8 = 1; react1 = 0; low8 = 0; low1 = 0;
        clear_logs();

        // Reset held with a pending request
        repeat (2) begin
            tick();
            cmp("reset busy", {63'd0, busy8}, 64'd0);
            cmp("reset tx_start", {63'd0, txs8}, 64'd0);
            cmp("reset tx_data", {56'd0, txd8}, 64'd0);
            cmp("reset leds", {61'd0, leds8}, 64'd0);
            cmp("reset done", {63'd0, done8}, 64'd0);
        end
        rst = 1;
        tick();
        cmp("busy one edge after release", {63'd0, busy8}, 64'd1);

        // Full read-back; bank rewritten and request held mid-transfer
        repeat (30) tick();
        conf8 = {$urandom, $urandom};
        wait_done8("full read-back completes", 600);
        repeat (30) tick();
        cmp("strobe count", 64'(log8.size()), 64'd8);
        cmp("done count", 64'(dcnt8), 64'd1);
        for (int i = 0; i < 8 && i < log8.size(); i++) begin
            cmp("byte order", {56'd0, log8[i]}, 64'(i + 1));
            cmp("leds order", {61'd0, led_log8[i]}, 64'(i));
        end
        cmp("leds hold last", {61'd0, leds8}, 64'd7);

        // Release and re-request with new data
        clear_logs();
        start8 = 0;
        repeat (2) tick();
        conf8 = 64'h8877665544332211;
        start8 = 1;
        wait_done8("second read-back completes", 600);
        tick();
        cmp("second strobe count", 64'(log8.size()), 64'd8);
        for (int i = 0; i < 8 && i < log8.size(); i++)
            cmp("second byte order", {56'd0, log8[i]}, 64'(8'h11 * (i + 1)));

        // Back-pressure at start
        clear_logs();
        start8 = 0;
        repeat (2) tick();
        react8 = 0; rdy8 = 0; start8 = 1;
        repeat (20) tick();
        cmp("no strobe while not ready", 64'(log8.size()), 64'd0);
        cmp("busy while stalled", {63'd0, busy8}, 64'd1);
        rdy8 = 1; react8 = 1;
        tick();
        cmp("strobe one edge after ready", {63'd0, txs8}, 64'd1);
        cmp("stalled first byte", {56'd0, txd8}, 64'h11);
        wait_done8("stalled read-back completes", 600);

        // Reset after the third strobe
        clear_logs();
        start8 = 0;
        repeat (2) tick();
        conf8 = 64'h0807060504030201;
        start8 = 1;
        for (int k = 0; k < 400 && log8.size() < 3; k++) tick();
        cmp("third strobe reached", 64'(log8.size()), 64'd3);
        rst = 0;
        tick();
        cmp("mid reset busy", {63'd0, busy8}, 64'd0);
        cmp("mid reset tx_data", {56'd0, txd8}, 64'd0);
        cmp("mid reset leds", {61'd0, leds8}, 64'd0);
        tick();
        rst = 1; start8 = 0;
        clear_logs();
        repeat (30) tick();
        cmp("no strobe after abort", 64'(log8.size()), 64'd0);
        start8 = 1;
        for (int k = 0; k < 100 && log8.size() < 1; k++) tick();
        cmp("restart first byte", {56'd0, (log8.size() > 0) ? log8[0] : 8'hxx}, 64'h01);
        wait_done8("restart completes", 600);
        start8 = 0;

        // Single-byte instance
        conf1 = 8'hA5; rdy1 = 1; react1 = 1; start1 = 1;
        for (int k = 0; k < 100 && dcnt1 == 0; k++) tick();
        tick();
        cmp("n1 strobe count", 64'(log1.size()), 64'd1);
        cmp("n1 byte", {56'd0, (log1.size() > 0) ? log1[0] : 8'hxx}, 64'hA5);
        cmp("n1 done count", 64'(dcnt1), 64'd1);

        // Randomized traffic, checked cycle by cycle against the model
        react8 = 0; react1 = 0;
        for (int k = 0; k < 4000; k++) begin
            tick();
            rst   = ($urandom_range(0, 399) != 0);
            rdy8  = ($urandom_range(0, 3) != 0);
            rdy1  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) start8 = ~start8;
            if ($urandom_range(0, 7) == 0)  start1 = ~start1;
            if ($urandom_range(0, 3) == 0)  conf8 = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0)  conf1 = 8'($urandom);
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rd_control.md
# rd_control

Read-back controller for the UART configuration path; the transmit-side counterpart of the write controller. On a start request it snapshots the configuration register bank and sends it byte by byte through the UART transmitter, sequencing each byte with the transmitter's ready handshake. It sits between the configuration registers and the UART TX, alongside the write controller, and drives a progress indication on board LEDs.

## Interface
- NUM_BYTES, default 8: bytes sent per read-back; legal range 1..8.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- start_rd  in  1  read-back request, level; sampled only in IDLE and HOLD.
- conf_data  in  8*NUM_BYTES  configuration register bank, byte 0 = conf_data[7:0].
- tx_rdy  in  1  UART TX idle flag (1 = can accept a byte).
- tx_data  out  8  byte to transmit; registered.
- tx_start  out  1  one-cycle load strobe to UART TX; registered.
- done_rd  out  1  one-cycle pulse when the last byte has finished transmitting.
- busy  out  1  high from accepted start until done_rd.
- rd_leds  out  3  index of byte currently in flight (0..NUM_BYTES-1).

## Operation
- States: IDLE, SEND, WAIT_BUSY, WAIT_IDLE, DONE, HOLD.
- IDLE: start_rd=1 -> snapshot conf_data into internal shift register, byte counter := 0, busy := 1, go to SEND. Later conf_data changes do not affect the transfer.
- SEND: tx_rdy=1 -> tx_data := shreg[7:0], tx_start := 1 (next cycle only), go to WAIT_BUSY. tx_rdy=0 -> stay in SEND, no strobe.
- WAIT_BUSY: wait for tx_rdy=0 (transmitter took the byte), then go to WAIT_IDLE. No timeout.
- WAIT_IDLE: wait for tx_rdy=1. If counter = NUM_BYTES-1 -> DONE. Otherwise counter +1, shreg shifts right by 8, go to SEND.
- DONE: done_rd := 1 for one cycle, busy := 0, go to HOLD.
- HOLD: stay until start_rd=0, then IDLE. A held-high start_rd never retriggers. A request arriving while busy is ignored.
- rd_leds = byte counter; holds the last index (NUM_BYTES-1) through DONE/HOLD; cleared on entry to SEND from IDLE.
- Counter is 3 bits. No wrap past NUM_BYTES-1.

## Timing
- Reset (rst=0 at a rising edge): state IDLE; tx_data=0, tx_start=0, done_rd=0, busy=0, rd_leds=0; shreg and counter cleared. Reset mid-transfer aborts immediately. No further tx_start is issued, and a byte already handed to the UART is not recalled.
- Latency: start_rd sampled at edge N -> busy high after N; tx_start high for the cycle after edge N+1 if tx_rdy=1 at N+1.
- tx_start is never high on two consecutive cycles. tx_data is stable from the tx_start cycle until the next tx_start.
- Byte-to-byte gap: next tx_start occurs 2 edges after tx_rdy returns to 1 (WAIT_IDLE->SEND, SEND->strobe).
- done_rd is asserted on the cycle after the edge at which tx_rdy returns to 1 for the final byte. busy falls in the same cycle.
- tx_rdy low when entering SEND: stall with no strobe until it is high.
- tx_rdy glitch high during WAIT_BUSY is ignored. Only a 0 advances the state.
- NUM_BYTES=1: single byte, then DONE.

## Test plan
- Reset: hold rst=0 for 2 cycles with start_rd=1 -> all outputs 0; release -> busy=1 one edge later.
- Full read-back with NUM_BYTES=8, conf_data=0x0807060504030201, and a TX model (tx_rdy drops the cycle after tx_start, low for 10 cycles). Required: tx_data sequence 0x01..0x08, exactly 8 tx_start pulses, rd_leds 0..7, one done_rd pulse.
- Snapshot and retrigger: change conf_data and keep start_rd=1 mid-transfer -> transmitted bytes unchanged, no second transfer. Drop start_rd, then raise it -> new transfer with new data.
- Back-pressure: tx_rdy=0 for 20 cycles at start -> no tx_start until tx_rdy=1, then the strobe arrives 1 edge later.
- Reset mid-operation: rst=0 after byte 3 is strobed -> outputs 0, no further strobes. Restart -> byte sequence begins again at 0x01.
- NUM_BYTES=1 instance, conf_data=0xA5 -> one tx_start with tx_data=0xA5, then done_rd.
